// File: rtl/ram_access_ctrl.sv
// Table-RAM front end: post-reset init sweep, then valid/ready write and read arbitration.
// Define RAM_ACCESS_BYPASS_EN to forward same-cycle write data to a colliding read.
module ram_access_ctrl #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_resp_valid,
  input  logic                  rd_resp_ready,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    run_ok;
  logic                    wr_accept;
  logic                    rd_accept;
  logic [DATA_WIDTH-1:0]   fwd_data;
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt      = state;
    run_ok         = (state == RUN) && !rst;
    init_done      = run_ok;
    wr_ready       = run_ok;
    rd_ready       = run_ok && (!vld_p1 || rd_resp_ready);
    wr_accept      = wr_valid && wr_ready;
    rd_accept      = rd_valid && rd_ready;
    ram_write_en   = 1'b0;
    ram_write_addr = wr_addr;
    ram_write_data = wr_data;
    ram_read_addr  = rd_addr;
    fwd_data       = ram_read_data;
    if ((state == INIT) && (init_cnt == LAST_ADDR)) state_nxt = RUN;
    // Reset gates the write strobe so a stale RUN state cannot leak a write.
    if (!rst) begin
      if (state == INIT) begin
        ram_write_en   = 1'b1;
        ram_write_addr = init_cnt;
        ram_write_data = INIT_VALUE;
      end else begin
        ram_write_en   = wr_accept;
      end
    end
`ifdef RAM_ACCESS_BYPASS_EN
    if (wr_accept && (wr_addr == rd_addr)) fwd_data = wr_data;
`endif
  end

  // Stage p1: registered read response, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (rd_accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= fwd_data;
    end else if (rd_resp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign rd_resp_valid = vld_p1;
  assign rd_resp_data  = data_p1;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural async-read/sync-write table RAM.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [5:0]  rd_addr;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [63:0] rd_resp_data;
  logic        ram_write_en;
  logic [5:0]  ram_write_addr;
  logic [63:0] ram_write_data;
  logic [5:0]  ram_read_addr;
  logic [63:0] ram_read_data;

  logic        preload;
  logic [63:0] mem [64];

  int checks = 0;
  int errors = 0;

`ifdef RAM_ACCESS_BYPASS_EN
  localparam logic [63:0] EXP_COLLIDE = 64'h1;
`else
  localparam logic [63:0] EXP_COLLIDE = 64'h0;
`endif

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(64), .INIT_VALUE(64'h0)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
  );

  // Table RAM model; preload fills it with non-zero garbage so the sweep is observable.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
    end else if (ram_write_en) begin
      mem[ram_write_addr] <= ram_write_data;
    end
  end
  assign ram_read_data = mem[ram_read_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expects to be entered in the first INIT cycle; leaves off in the first RUN cycle.
  task automatic sweep_check();
    for (int c = 0; c < 64; c++) begin
      #1;
      chk("init_done_low", init_done, 0);
      chk("sweep_we", ram_write_en, 1);
      chk("sweep_addr", ram_write_addr, 64'(c));
      chk("sweep_data", ram_write_data, 64'h0);
      chk("init_wr_ready", wr_ready, 0);
      chk("init_rd_ready", rd_ready, 0);
      chk("init_resp_valid", rd_resp_valid, 0);
      if (c == 63) begin
        wr_valid = 1'b0;
        rd_valid = 1'b0;
      end
      tick();
    end
    #1;
    chk("init_done_high", init_done, 1);
    chk("run_wr_ready", wr_ready, 1);
    chk("run_rd_ready", rd_ready, 1);
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    wr_valid = 1'b1; wr_addr = 6'd33; wr_data = '1;
    rd_valid = 1'b1; rd_addr = 6'd2; rd_resp_ready = 1'b1;

    // Reset held for three edges with requests pending
    tick(); preload = 1'b0;
    tick(); tick();
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_we", ram_write_en, 0);
    chk("rst_resp_valid", rd_resp_valid, 0);
    chk("rst_resp_data", rd_resp_data, 64'h0);
    rst = 1'b0;
    sweep_check();

    // Whole table reads back INIT_VALUE, one read per cycle
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin rd_valid = 1'b1; rd_addr = 6'(i); end
      else rd_valid = 1'b0;
      #1;
      if (i < 64) chk("sweep_rd_ready", rd_ready, 1);
      if (i > 0) begin
        chk("sweep_rd_valid", rd_resp_valid, 1);
        chk("sweep_rd_data", rd_resp_data, 64'h0);
      end
      tick();
    end
    #1; chk("sweep_rd_idle", rd_resp_valid, 0);

    // Write 5 then read it back
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 64'hDEAD_BEEF_0000_0005;
    #1;
    chk("wr5_we", ram_write_en, 1);
    chk("wr5_addr", ram_write_addr, 64'd5);
    chk("wr5_data", ram_write_data, 64'hDEAD_BEEF_0000_0005);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd5;
    #1;
    chk("wr5_idle_we", ram_write_en, 0);
    chk("rd5_ready", rd_ready, 1);
    chk("rd5_raddr", ram_read_addr, 64'd5);
    chk("rd5_not_yet", rd_resp_valid, 0);
    tick();
    rd_valid = 1'b0;
    #1;
    chk("rd5_valid", rd_resp_valid, 1);
    chk("rd5_data", rd_resp_data, 64'hDEAD_BEEF_0000_0005);
    tick(); #1;
    chk("rd5_done", rd_resp_valid, 0);

    // Fill 0..7 with distinct words, then read them back-to-back
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 6'(i); wr_data = 64'h100 + 64'(i);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin rd_valid = 1'b1; rd_addr = 6'(i); end
      else rd_valid = 1'b0;
      #1;
      if (i > 0) begin
        chk("b2b_valid", rd_resp_valid, 1);
        chk("b2b_data", rd_resp_data, 64'h100 + 64'(i - 1));
      end
      tick();
    end
    #1; chk("b2b_idle", rd_resp_valid, 0);

    // Response stall for four cycles with a new read waiting
    rd_valid = 1'b1; rd_addr = 6'd3;
    tick();
    rd_resp_ready = 1'b0; rd_addr = 6'd4;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_valid", rd_resp_valid, 1);
      chk("stall_data", rd_resp_data, 64'h103);
      chk("stall_rd_ready", rd_ready, 0);
      tick();
    end
    rd_resp_ready = 1'b1;
    #1;
    chk("release_rd_ready", rd_ready, 1);
    chk("release_data", rd_resp_data, 64'h103);
    tick();
    rd_valid = 1'b0;
    #1;
    chk("after_stall_valid", rd_resp_valid, 1);
    chk("after_stall_data", rd_resp_data, 64'h104);
    tick(); #1;
    chk("after_stall_idle", rd_resp_valid, 0);

    // Same-cycle write and read of address 9
    wr_valid = 1'b1; wr_addr = 6'd9; wr_data = 64'h1;
    rd_valid = 1'b1; rd_addr = 6'd9;
    #1;
    chk("collide_wr_ready", wr_ready, 1);
    chk("collide_rd_ready", rd_ready, 1);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd9;
    #1;
    chk("collide_valid", rd_resp_valid, 1);
    chk("collide_data", rd_resp_data, EXP_COLLIDE);
    tick();
    rd_valid = 1'b0;
    #1;
    chk("addr9_written", rd_resp_data, 64'h1);

    // Reset mid-run with a stalled response pending
    tick();
    rd_valid = 1'b1; rd_addr = 6'd5; rd_resp_ready = 1'b0;
    tick();
    rd_valid = 1'b0;
    #1;
    chk("pend_valid", rd_resp_valid, 1);
    chk("pend_data", rd_resp_data, 64'h105);
    rst = 1'b1;
    #1;
    chk("midrst_init_done", init_done, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    chk("midrst_rd_ready", rd_ready, 0);
    tick();
    rst = 1'b0; rd_resp_ready = 1'b1;
    #1;
    chk("midrst_resp_dropped", rd_resp_valid, 0);
    chk("midrst_resp_data", rd_resp_data, 64'h0);
    sweep_check();

    // Earlier writes are wiped by the repeated sweep
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin rd_valid = 1'b1; rd_addr = (i == 0) ? 6'd5 : (i == 1) ? 6'd9 : 6'd2; end
      else rd_valid = 1'b0;
      #1;
      if (i > 0) begin
        chk("wiped_valid", rd_resp_valid, 1);
        chk("wiped_data", rd_resp_data, 64'h0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
